// File: rtl/str_elastic_pipeline.sv
// Elastic valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Optional tail parity check enabled by defining STR_PIPE_PARITY_EN.
module str_elastic_pipeline #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy
`ifdef STR_PIPE_PARITY_EN
  ,
  output logic                  out_parity_err
`endif
);

  logic [DEPTH-1:0]                 vld;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] dat;
  logic [DEPTH-1:0]                 go;
  logic [DEPTH-1:0]                 load;
  logic                             in_xfer;

`ifdef STR_PIPE_PARITY_EN
  logic [DEPTH-1:0]                 par;
`endif

  // go[i]: the word in stage i may leave; resolved tail-first so a stalled
  // tail only blocks the contiguous run of valid stages behind it.
  always_comb begin
    go            = '0;
    go[DEPTH-1]   = out_ready;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      go[DEPTH-1-k] = !vld[DEPTH-k] | go[DEPTH-k];
    end
  end

  always_comb begin
    load = ~vld | go;
  end

  assign in_ready  = load[0] & !flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = vld[DEPTH-1] & !flush;
  assign out_data  = dat[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CNT_W'(vld[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      dat <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (load[0]) begin
        vld[0] <= in_xfer;
        dat[0] <= in_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end
  end

`ifdef STR_PIPE_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= '0;
    end else if (!flush) begin
      if (load[0]) begin
        par[0] <= ^in_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          par[i] <= par[i-1];
        end
      end
    end
  end

  assign out_parity_err = out_valid & ((^out_data) != par[DEPTH-1]);
`endif

endmodule

// File: tb/tb_str_elastic_pipeline.sv
// Self-checking bench for str_elastic_pipeline: directed table, hand sequences and
// randomized traffic checked against a queue-of-positions reference model.
module tb_str_elastic_pipeline;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] occupancy;
`ifdef STR_PIPE_PARITY_EN
  logic          out_parity_err;
`endif

  str_elastic_pipeline #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef STR_PIPE_PARITY_EN
    ,
    .out_parity_err (out_parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: words oldest-first with their stage position (0 = head).
  logic [DW-1:0] mq_d[$];
  int            mq_p[$];

  logic          last_ir, last_ov;
  logic [DW-1:0] last_od;
  int            last_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive after negedge, check pre-edge outputs, advance the model.
  task automatic cycle(input logic fl, input logic iv, input logic [DW-1:0] d, input logic ordy);
    int np[$];
    int lim;
    int nxt;
    bit ex_ov, ex_ir, ox;
    @(negedge clk);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    ex_ov = !fl && (mq_d.size() > 0) && (mq_p[0] == DEPTH - 1);
    ox    = ex_ov && ordy;
    lim   = DEPTH - 1;
    for (int j = (ox ? 1 : 0); j < mq_p.size(); j++) begin
      nxt = (mq_p[j] + 1 < lim) ? mq_p[j] + 1 : lim;
      np.push_back(nxt);
      lim = nxt - 1;
    end
    ex_ir = !fl && (lim >= 0);
    chk("in_ready", 32'(in_ready), 32'(ex_ir));
    chk("out_valid", 32'(out_valid), 32'(ex_ov));
    chk("occupancy", 32'(occupancy), 32'(mq_d.size()));
    if (ex_ov) chk("out_data", out_data, mq_d[0]);
`ifdef STR_PIPE_PARITY_EN
    chk("parity_err_clean", 32'(out_parity_err), 32'd0);
`endif
    last_ir  = in_ready;
    last_ov  = out_valid;
    last_od  = out_data;
    last_occ = int'(occupancy);
    if (fl) begin
      mq_d.delete();
      mq_p.delete();
    end else begin
      if (ox) void'(mq_d.pop_front());
      mq_p = np;
      if (iv && ex_ir) begin
        mq_d.push_back(d);
        mq_p.push_back(0);
      end
    end
  endtask

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
    int            e_occ;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc, first_ov, recv, max_occ, dead_seen, sent, ov_seen, lat;
    logic [DW-1:0] exp_word;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Test 1: streaming 1..8 with the consumer always ready
    first_acc = -1; first_ov = -1; recv = 0; max_occ = 0; exp_word = 32'd1;
    for (int c = 0; c < 16; c++) begin
      cycle(1'b0, (c < 8), DW'(c + 1), 1'b1);
      if (c < 8 && last_ir && first_acc < 0) first_acc = c;
      if (last_ov && first_ov < 0) first_ov = c;
      if (last_occ > max_occ) max_occ = last_occ;
      if (c < 8) chk("stream_in_ready", 32'(last_ir), 32'd1);
      if (last_ov) begin
        chk("stream_order", last_od, exp_word);
        exp_word++;
        recv++;
      end
    end
    chk("stream_latency", 32'(first_ov - first_acc), DEPTH);
    chk("stream_count", 32'(recv), 32'd8);
    chk("stream_peak_occ", 32'(max_occ), DEPTH);

    // Test 2: fill against a stalled consumer, then drain (table-driven)
    tbl[0]  = '{1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h0,  0};
    tbl[1]  = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h0,  1};
    tbl[2]  = '{1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 32'h0,  2};
    tbl[3]  = '{1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 32'h0,  3};
    tbl[4]  = '{1'b0, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA0, 4};
    tbl[5]  = '{1'b0, 1'b1, 32'hA5, 1'b0, 1'b0, 1'b1, 32'hA0, 4};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hA0, 4};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA0, 4};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA1, 3};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2, 2};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA3, 1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  0};
    for (int unsigned r = 0; r < 12; r++) begin
      cycle(tbl[r].fl, tbl[r].iv, tbl[r].d, tbl[r].ordy);
      chk($sformatf("tbl%0d_in_ready", r), 32'(last_ir), 32'(tbl[r].e_ir));
      chk($sformatf("tbl%0d_out_valid", r), 32'(last_ov), 32'(tbl[r].e_ov));
      chk($sformatf("tbl%0d_occ", r), 32'(last_occ), 32'(tbl[r].e_occ));
      if (tbl[r].e_ov) chk($sformatf("tbl%0d_out_data", r), last_od, tbl[r].e_od);
    end

    // Test 3: sparse words with a consumer toggling ready every cycle
    sent = 0; recv = 0; dead_seen = 0;
    for (int c = 0; c < 30; c++) begin
      logic iv3;
      logic [DW-1:0] d3;
      iv3 = (c % 5 == 0) && (sent < 4);
      d3  = (sent == 0) ? 32'hDEAD : 32'hBEEF_0000 + DW'(sent);
      cycle(1'b0, iv3, d3, c[0]);
      if (iv3 && last_ir) sent++;
      if (last_ov && c[0]) begin
        recv++;
        if (last_od == 32'hDEAD) dead_seen++;
      end
    end
    chk("toggle_sent", 32'(sent), 32'd4);
    chk("toggle_recv", 32'(recv), 32'd4);
    chk("toggle_dead_once", 32'(dead_seen), 32'd1);

    // Test 4: flush with three words held and an input offered
    for (int unsigned k = 0; k < 3; k++) cycle(1'b0, 1'b1, 32'hB0 + k, 1'b0);
    cycle(1'b1, 1'b1, 32'hB9, 1'b1);
    chk("flush_in_ready", 32'(last_ir), 32'd0);
    chk("flush_out_valid", 32'(last_ov), 32'd0);
    ov_seen = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (c == 0) chk("post_flush_occ", 32'(last_occ), 32'd0);
      if (last_ov) ov_seen++;
    end
    chk("flushed_never_out", 32'(ov_seen), 32'd0);

    // Test 5: asynchronous reset with two words in flight
    cycle(1'b0, 1'b1, 32'hC0, 1'b0);
    cycle(1'b0, 1'b1, 32'hC1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_occ", 32'(occupancy), 32'd0);
    mq_d.delete();
    mq_p.delete();
    @(negedge clk);
    rst = 1'b0;
    lat = -1;
    cycle(1'b0, 1'b1, 32'h55, 1'b1);
    for (int c = 1; c < 12 && lat < 0; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (last_ov) begin
        lat = c;
        chk("post_rst_data", last_od, 32'h55);
      end
    end
    chk("post_rst_latency", 32'(lat), DEPTH);

`ifdef STR_PIPE_PARITY_EN
    // Test 6: corrupt the tail word and observe the parity flag
    cycle(1'b0, 1'b1, 32'hF1, 1'b0);
    for (int unsigned k = 0; k < DEPTH; k++) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("par_tail_valid", 32'(last_ov), 32'd1);
    force dut.dat[DEPTH-1] = 32'hF0;
    #1;
    chk("par_err_set", 32'(out_parity_err), 32'd1);
    release dut.dat[DEPTH-1];
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
`endif

    // Randomized traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
